// File: rtl/riscv_pipeline_top.sv
// Five-stage in-order RV32I-subset core (lw/sw/R-ALU/I-ALU/beq) with local instruction ROM
// and data RAM; pipeline registers and hazard decisions are exported for observation.
module riscv_pipeline_top #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "memfile.hex"
) (
  input  logic        clk,
  input  logic        rst,
  output logic        PCSrcE,
  output logic        RegWriteE, RegWriteM, RegWriteW,
  output logic        ALUSrcE,
  output logic        MemWriteE, MemWriteM,
  output logic        ResultSrcE, ResultSrcM, ResultSrcW,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [4:0]  RD_E, RD_M, RDW,
  output logic [4:0]  RS1_E, RS2_E,
  output logic [1:0]  ForwardAE, ForwardBE,
  output logic [31:0] InstrD, PCD, PCPlus4D,
  output logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
  output logic [31:0] PCTargetE,
  output logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M,
  output logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W,
  output logic [31:0] ResultW
);
  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  function automatic logic [31:0] alu_op(input logic [2:0] ctrl,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
    case (ctrl)
      3'b000:  alu_op = a + b;
      3'b001:  alu_op = a - b;
      3'b010:  alu_op = a & b;
      3'b011:  alu_op = a | b;
      3'b101:  alu_op = {31'd0, (a < b)};
      default: alu_op = 32'd0;
    endcase
  endfunction

  // ---- Fetch ----
  logic [31:0] pc_f, pc_plus4_f, instr_f;
  assign pc_plus4_f = pc_f + 32'd4;
  assign instr_f    = imem[pc_f[IA_W+1:2]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_f <= '0;
    else      pc_f <= PCSrcE ? PCTargetE : pc_plus4_f;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD <= '0; PCD <= '0; PCPlus4D <= '0;
    end else if (PCSrcE) begin
      InstrD <= '0; PCD <= '0; PCPlus4D <= '0;
    end else begin
      InstrD <= instr_f; PCD <= pc_f; PCPlus4D <= pc_plus4_f;
    end
  end

  // ---- Decode ----
  logic [6:0]  opcode_d;
  logic [2:0]  funct3_d, alu_ctrl_d;
  logic        reg_write_d, alu_src_d, mem_write_d, result_src_d, branch_d;
  logic [31:0] imm_d, rd1_d, rd2_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  assign opcode_d = InstrD[6:0];
  assign funct3_d = InstrD[14:12];
  assign rd_d     = InstrD[11:7];
  assign rs1_d    = InstrD[19:15];
  assign rs2_d    = InstrD[24:20];
  assign rd1_d    = (rs1_d == 5'd0) ? 32'd0 : rf[rs1_d];
  assign rd2_d    = (rs2_d == 5'd0) ? 32'd0 : rf[rs2_d];

  always_comb begin
    reg_write_d = 1'b0; alu_src_d = 1'b0; mem_write_d = 1'b0;
    result_src_d = 1'b0; branch_d = 1'b0; alu_ctrl_d = 3'b000;
    imm_d = {{20{InstrD[31]}}, InstrD[31:20]};
    case (opcode_d)
      7'b0000011: if (funct3_d == 3'b010) begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 1'b1;
      end
      7'b0100011: if (funct3_d == 3'b010) begin
        mem_write_d = 1'b1; alu_src_d = 1'b1;
        imm_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      7'b0110011, 7'b0010011: begin
        alu_src_d = (opcode_d == 7'b0010011);
        reg_write_d = 1'b1;
        case (funct3_d)
          3'b000:  alu_ctrl_d = (!alu_src_d && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_d = 3'b101;
          3'b110:  alu_ctrl_d = 3'b011;
          3'b111:  alu_ctrl_d = 3'b010;
          default: begin reg_write_d = 1'b0; alu_src_d = 1'b0; end
        endcase
      end
      7'b1100011: if (funct3_d == 3'b000) begin
        branch_d = 1'b1; alu_ctrl_d = 3'b001;
        imm_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Falling-edge write lets a same-cycle decode read pick up the writeback value.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWriteW && RDW != 5'd0) begin
      rf[RDW] <= ResultW;
    end
  end

  // ---- D/E boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || PCSrcE) begin
      if (!rst || PCSrcE) begin
        RegWriteE <= 1'b0; ALUSrcE <= 1'b0; MemWriteE <= 1'b0; ResultSrcE <= 1'b0;
        BranchE <= 1'b0; ALUControlE <= '0; RD_E <= '0; RS1_E <= '0; RS2_E <= '0;
        RD1_E <= '0; RD2_E <= '0; Imm_Ext_E <= '0; PCE <= '0; PCPlus4E <= '0;
      end
    end else begin
      RegWriteE <= reg_write_d; ALUSrcE <= alu_src_d; MemWriteE <= mem_write_d;
      ResultSrcE <= result_src_d; BranchE <= branch_d; ALUControlE <= alu_ctrl_d;
      RD_E <= rd_d; RS1_E <= rs1_d; RS2_E <= rs2_d;
      RD1_E <= rd1_d; RD2_E <= rd2_d; Imm_Ext_E <= imm_d; PCE <= PCD; PCPlus4E <= PCPlus4D;
    end
  end

  // ---- Execute ----
  logic signed [31:0] src_a_e, src_b_e, write_data_e;
  logic [31:0]        alu_result_e;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)     ForwardAE = 2'b10;
    else if (RegWriteW && RDW != 5'd0 && RDW == RS1_E)  ForwardAE = 2'b01;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)     ForwardBE = 2'b10;
    else if (RegWriteW && RDW != 5'd0 && RDW == RS2_E)  ForwardBE = 2'b01;
  end

  assign src_a_e      = (ForwardAE == 2'b10) ? ALU_ResultM : (ForwardAE == 2'b01) ? ResultW : RD1_E;
  assign write_data_e = (ForwardBE == 2'b10) ? ALU_ResultM : (ForwardBE == 2'b01) ? ResultW : RD2_E;
  assign src_b_e      = ALUSrcE ? Imm_Ext_E : write_data_e;
  assign alu_result_e = alu_op(ALUControlE, src_a_e, src_b_e);
  assign PCTargetE    = PCE + Imm_Ext_E;
  assign PCSrcE       = BranchE && (alu_result_e == 32'd0);

  // ---- E/M boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM <= 1'b0; MemWriteM <= 1'b0; ResultSrcM <= 1'b0; RD_M <= '0;
      ALU_ResultM <= '0; WriteDataM <= '0; PCPlus4M <= '0;
    end else begin
      RegWriteM <= RegWriteE; MemWriteM <= MemWriteE; ResultSrcM <= ResultSrcE; RD_M <= RD_E;
      ALU_ResultM <= alu_result_e; WriteDataM <= write_data_e; PCPlus4M <= PCPlus4E;
    end
  end

  // ---- Memory ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else if (MemWriteM) begin
      dmem[ALU_ResultM[DA_W+1:2]] <= WriteDataM;
    end
  end

  // ---- M/W boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW <= 1'b0; ResultSrcW <= 1'b0; RDW <= '0;
      ALU_ResultW <= '0; ReadDataW <= '0; PCPlus4W <= '0;
    end else begin
      RegWriteW <= RegWriteM; ResultSrcW <= ResultSrcM; RDW <= RD_M;
      ALU_ResultW <= ALU_ResultM; ReadDataW <= dmem[ALU_ResultM[DA_W+1:2]]; PCPlus4W <= PCPlus4M;
    end
  end

  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;
endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Scoreboard bench for riscv_pipeline_top: a directed program is loaded into the ROM, expected
// E-stage, store, branch and writeback events are queued, and monitors compare as they occur.
module tb_riscv_pipeline_top;
  logic        clk, rst;
  logic        PCSrcE, RegWriteE, RegWriteM, RegWriteW, ALUSrcE, MemWriteE, MemWriteM;
  logic        ResultSrcE, ResultSrcM, ResultSrcW, BranchE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RD_E, RD_M, RDW, RS1_E, RS2_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, PCTargetE;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M, ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

  riscv_pipeline_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
    .BranchE(BranchE), .ALUControlE(ALUControlE), .RD_E(RD_E), .RD_M(RD_M), .RDW(RDW),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ResultW(ResultW)
  );

  typedef struct { logic [31:0] pc; logic [1:0] fa; logic [1:0] fb; logic [2:0] aluc; } e_exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] res; logic src; } w_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } s_exp_t;
  typedef struct { logic [31:0] pc; logic [31:0] tgt; } b_exp_t;

  e_exp_t eq[$];
  w_exp_t wq[$];
  s_exp_t sq[$];
  b_exp_t bq[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] prog [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_empty(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected-event required=no-event", name);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors sample on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (RegWriteE || MemWriteE || BranchE) begin
        if (eq.size() == 0) chk_empty("e_stage");
        else begin
          e_exp_t e;
          e = eq.pop_front();
          chk("e_pc", PCE, e.pc);
          chk("e_fwdA", {30'd0, ForwardAE}, {30'd0, e.fa});
          chk("e_fwdB", {30'd0, ForwardBE}, {30'd0, e.fb});
          chk("e_aluctl", {29'd0, ALUControlE}, {29'd0, e.aluc});
        end
      end
      if (PCSrcE) begin
        if (bq.size() == 0) chk_empty("branch");
        else begin
          b_exp_t b;
          b = bq.pop_front();
          chk("br_pce", PCE, b.pc);
          chk("br_target", PCTargetE, b.tgt);
        end
      end
      if (MemWriteM) begin
        if (sq.size() == 0) chk_empty("store");
        else begin
          s_exp_t s;
          s = sq.pop_front();
          chk("st_addr", ALU_ResultM, s.addr);
          chk("st_data", WriteDataM, s.data);
        end
      end
      if (RegWriteW) begin
        if (wq.size() == 0) chk_empty("writeback");
        else begin
          w_exp_t w;
          w = wq.pop_front();
          chk("wb_rd", {27'd0, RDW}, {27'd0, w.rd});
          chk("wb_result", ResultW, w.res);
          chk("wb_src", {31'd0, ResultSrcW}, {31'd0, w.src});
        end
      end
    end
  end

  task automatic push_e(input logic [31:0] pc, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [2:0] aluc);
    e_exp_t e;
    e.pc = pc; e.fa = fa; e.fb = fb; e.aluc = aluc;
    eq.push_back(e);
  endtask

  task automatic push_w(input logic [4:0] rd, input logic [31:0] res, input logic src);
    w_exp_t w;
    w.rd = rd; w.res = res; w.src = src;
    wq.push_back(w);
  endtask

  initial begin
    s_exp_t s;
    b_exp_t b;
    rst = 1'b0;
    prog = '{32'h00500093,   // 0  addi x1,x0,5
             32'h00A00113,   // 4  addi x2,x0,10
             32'h002081B3,   // 8  add  x3,x1,x2
             32'h00302423,   // 12 sw   x3,8(x0)
             32'h00000013,   // 16 nop
             32'h00802203,   // 20 lw   x4,8(x0)
             32'h402082B3,   // 24 sub  x5,x1,x2
             32'h0012A333,   // 28 slt  x6,x5,x1
             32'h0020F433,   // 32 and  x8,x1,x2
             32'h0020E4B3,   // 36 or   x9,x1,x2
             32'h00020533,   // 40 add  x10,x4,x0
             32'h00108663,   // 44 beq  x1,x1,+12
             32'h00100593,   // 48 addi x11,x0,1 (wrong path)
             32'h00200613,   // 52 addi x12,x0,2 (wrong path)
             32'h00700013,   // 56 addi x0,x0,7
             32'h000003B3};  // 60 add  x7,x0,x0
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
    for (int i = 0; i < 16; i++) dut.imem[i] = prog[i];

    push_e(0, 2'b00, 2'b00, 3'b000);  push_w(5'd1, 32'd5, 1'b0);
    push_e(4, 2'b00, 2'b00, 3'b000);  push_w(5'd2, 32'd10, 1'b0);
    push_e(8, 2'b01, 2'b10, 3'b000);  push_w(5'd3, 32'd15, 1'b0);
    push_e(12, 2'b00, 2'b10, 3'b000);
    s.addr = 32'd8; s.data = 32'd15; sq.push_back(s);
    push_e(16, 2'b00, 2'b00, 3'b000); push_w(5'd0, 32'd0, 1'b0);
    push_e(20, 2'b00, 2'b00, 3'b000); push_w(5'd4, 32'd15, 1'b1);
    push_e(24, 2'b00, 2'b00, 3'b001); push_w(5'd5, 32'hFFFF_FFFB, 1'b0);
    push_e(28, 2'b10, 2'b00, 3'b101); push_w(5'd6, 32'd1, 1'b0);
    push_e(32, 2'b00, 2'b00, 3'b010); push_w(5'd8, 32'd0, 1'b0);
    push_e(36, 2'b00, 2'b00, 3'b011); push_w(5'd9, 32'd15, 1'b0);
    push_e(40, 2'b00, 2'b00, 3'b000); push_w(5'd10, 32'd15, 1'b0);
    push_e(44, 2'b00, 2'b00, 3'b001);
    b.pc = 32'd44; b.tgt = 32'd56; bq.push_back(b);
    push_e(56, 2'b00, 2'b00, 3'b000); push_w(5'd0, 32'd7, 1'b0);
    push_e(60, 2'b00, 2'b00, 3'b000); push_w(5'd7, 32'd0, 1'b0);

    #12;
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_InstrD", InstrD, 32'd0);
    chk("rst_PCE", PCE, 32'd0);
    chk("rst_ALU_ResultM", ALU_ResultM, 32'd0);
    chk("rst_ResultW", ResultW, 32'd0);
    chk("rst_ctrl", {26'd0, RegWriteE, RegWriteM, RegWriteW, MemWriteM, PCSrcE, BranchE}, 32'd0);
    #8 rst = 1'b1;

    @(posedge clk); #1;
    chk("first_PCD", PCD, 32'd0);
    chk("first_InstrD", InstrD, prog[0]);
    chk("first_PCPlus4D", PCPlus4D, 32'd4);

    repeat (40) @(posedge clk);
    #1;
    chk("e_queue_drained", eq.size(), 32'd0);
    chk("wb_queue_drained", wq.size(), 32'd0);
    chk("st_queue_drained", sq.size(), 32'd0);
    chk("br_queue_drained", bq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
